// File: rtl/link_pkg.sv
// Shared frame constants and receiver FSM encoding for the inter-router link.
package link_pkg;

    localparam int unsigned LINK_DATA_W = 55;
    localparam logic        START_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } rx_state_e;

endpackage : link_pkg

// File: rtl/rx_shifter.sv
// Payload shift register, bit counter and running parity of the bits shifted in.
module rx_shifter
    import link_pkg::*;
#(
    parameter int unsigned DATA_W = LINK_DATA_W,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_in,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              par_en,
    output logic              last_bit,
    output logic              par_ok,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;

    // Next value of shift register, counter and parity accumulator
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (clr) begin
            cnt_d = '0;
            par_d = 1'b0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[DATA_W-2:0], s_in};
            cnt_d   = cnt_q + CNT_W'(1);
            par_d   = par_q ^ s_in;
        end else if (par_en) begin
            par_d = par_q ^ s_in;
        end
    end

    // Shifter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    // Even parity over data plus parity bit leaves the accumulator at zero
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    assign par_ok   = ~par_q;
    assign data     = shreg_q;

endmodule : rx_shifter

// File: rtl/rx_deserializer.sv
// Serial link receiver: start-bit detect, MSB-first deserialize, one-deep holding
// register with valid/ack handshake. Define RX_PARITY_EN for a trailing even-parity bit.
module rx_deserializer
    import link_pkg::*;
#(
    parameter int unsigned DATA_W = LINK_DATA_W,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              S_Data,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Data_Valid,
    input  logic              RX_Ack,
    output logic              RX_Overrun,
    output logic              RX_Parity_Err
);

    rx_state_e         state_q, state_d;
    logic              s_data_q, s_data_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              par_err_q, par_err_d;
    logic              clr, shift_en, par_en;
    logic              last_bit, par_ok;
    logic [DATA_W-1:0] shreg;
    logic              ack_take, commit, frame_ok;

    rx_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk      (Clk_S),
        .rst_n    (Rst_n),
        .s_in     (s_data_q),
        .clr      (clr),
        .shift_en (shift_en),
        .par_en   (par_en),
        .last_bit (last_bit),
        .par_ok   (par_ok),
        .data     (shreg)
    );

    // FSM state register
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic, driven by the registered line sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (s_data_q == START_BIT) state_d = SHIFT;
`ifdef RX_PARITY_EN
            SHIFT:  if (last_bit) state_d = PARITY;
            PARITY: state_d = DONE;
`else
            SHIFT:  if (last_bit) state_d = DONE;
`endif
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter controls, commit decision and handshake
    always_comb begin
        s_data_d   = S_Data;
        clr        = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        commit     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        par_err_d  = 1'b0;
        ack_take   = rx_valid_q & RX_Ack;
`ifdef RX_PARITY_EN
        frame_ok   = par_ok;
`else
        frame_ok   = 1'b1;
`endif
        case (state_q)
            IDLE:   clr = (s_data_q == START_BIT);
            SHIFT:  shift_en = 1'b1;
`ifdef RX_PARITY_EN
            PARITY: par_en = 1'b1;
`endif
            DONE: begin
                if (!frame_ok) begin
                    par_err_d = 1'b1;
                end else if (!rx_valid_q || ack_take) begin
                    rx_data_d  = shreg;
                    rx_valid_d = 1'b1;
                    commit     = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (ack_take && !commit) rx_valid_d = 1'b0;
    end

    // Line sample and output registers
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            s_data_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            s_data_q   <= s_data_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            par_err_q  <= par_err_d;
        end
    end

    assign RX_Data       = rx_data_q;
    assign RX_Data_Valid = rx_valid_q;
    assign RX_Overrun    = overrun_q;

`ifdef RX_PARITY_EN
    assign RX_Parity_Err = par_err_q;
`else
    // No parity bit on the line: the accumulator and error flop go unused
    logic unused_par;
    assign unused_par    = par_ok ^ par_err_q;
    assign RX_Parity_Err = 1'b0;
`endif

endmodule : rx_deserializer

// File: doc/rx_deserializer.md
# rx_deserializer

Serial receive stage of the inter-router link. Samples the single-bit `S_Data` line produced by the link transmitter on the shared link clock and detects each frame's start bit. Deserializes the 55-bit payload MSB-first and presents it to the router's input logic through a valid/ack handshake. A holding register decouples frame reception from consumer latency, so one frame can be pending while the next is shifting in.

## Interface
Parameters:
- `DATA_W`, 55: payload width in bits; must match the transmitter's payload width.
- `CNT_W`, 6: bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- `Clk_S`  input  1: link clock, shared with the transmitter; all logic on its rising edge.
- `Rst_n`  input  1: asynchronous, active-low reset.
- `S_Data`  input  1: serial line; idles low.
- `RX_Data`  output  DATA_W: received payload; stable while `RX_Data_Valid` is high.
- `RX_Data_Valid`  output  1: holding register contains an unconsumed frame.
- `RX_Ack`  input  1: consumer takes the frame on any edge where `RX_Data_Valid` and `RX_Ack` are both high.
- `RX_Overrun`  output  1: one-cycle pulse; a completed frame was dropped because the holding register was full.
- `RX_Parity_Err`  output  1: one-cycle pulse, only when `RX_PARITY_EN` is defined; the completed frame was dropped for a parity mismatch.

## Operation
Frame format on `S_Data`:
- One start bit (1).
- DATA_W data bits, MSB first, one per `Clk_S`.
- With `RX_PARITY_EN`: one even-parity bit covering the data bits.
- The sender guarantees at least one idle-low cycle between frames.

State machine:
- `IDLE`: on sampling `S_Data`=1, clear the bit counter and go to `SHIFT`.
- `SHIFT`: on each edge, shift `S_Data` into the LSB of the shift register and increment the counter.
  - When counter = DATA_W-1, go to `PARITY` if `RX_PARITY_EN` is defined; otherwise go to `DONE`.
- `PARITY`: sample the parity bit and compare it against the XOR-reduction of the shift register; go to `DONE`.
- `DONE`: commit, then return to `IDLE`.

Commit rules (all evaluated in the `DONE` cycle):
- Parity mismatch: drop the frame and pulse `RX_Parity_Err`. The holding register and `RX_Data_Valid` are unchanged.
- Holding register empty, or being acked on this same edge: load `RX_Data` from the shift register. `RX_Data_Valid` is high from the next cycle.
- Holding register full and not being acked: drop the new frame and pulse `RX_Overrun`. Old data and `RX_Data_Valid` are unchanged.

Handshake:
- An ack with no commit on the same edge clears `RX_Data_Valid`. `RX_Data` keeps its last value.
- `RX_Ack` while `RX_Data_Valid` is low is ignored.

Other rules:
- `S_Data` is ignored in `DONE`; a start bit arriving there violates the idle guarantee and is missed.
- Reset mid-frame abandons the partial frame. After reset the FSM waits for a fresh start bit.

## Timing
- Reset values: state `IDLE`, counter 0, shift register 0, `RX_Data` 0, `RX_Data_Valid` 0, `RX_Overrun` 0, `RX_Parity_Err` 0.
- Start bit sampled at edge E0. Data bits are sampled at E1..E55; with `RX_PARITY_EN`, the parity bit is sampled at E56.
- `RX_Data_Valid` rises after E57 without parity and after E58 with parity. This is 2 cycles after the last sampled bit.
- Minimum frame-to-frame period is 58 cycles without parity and 59 with parity; back-to-back frames at this rate must all be received.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `RX_PARITY_EN` defined:
  - The frame carries a trailing even-parity bit and the `PARITY` state exists.
  - `RX_Parity_Err` is driven and frames with a parity mismatch are dropped.
- Not defined:
  - There is no parity bit and no `PARITY` state.
  - `RX_Parity_Err` is tied to 0.

## Structure
- Shared package `link_pkg`:
  - `LINK_DATA_W` = 55.
  - The start-bit value.
  - The FSM state encoding (`IDLE`, `SHIFT`, `PARITY`, `DONE`).
- The transmitter side imports the same frame constants.
- One sub-module, `rx_shifter`, holds the DATA_W-bit shift register, the bit counter and the parity accumulator. It exposes `shift_en`, `clr`, `last_bit`, `par_ok` and `data`.

## Test plan
- After reset, idle line for 10 cycles: all outputs 0, no `RX_Data_Valid`.
- Frame 55'h55_5555_5555_5555, `RX_Ack` held high: `RX_Data` = 55'h55_5555_5555_5555. `RX_Data_Valid` is high for exactly 1 cycle, rising 2 cycles after the last bit.
- Frames 55'h0 then 55'h7F_FFFF_FFFF_FFFF at the minimum period with `RX_Ack` held low: the first frame is held and the second completion pulses `RX_Overrun` once. After an ack, `RX_Data` still reads 55'h0.
- Frame 55'h1 pending, then a second frame 55'h2 completes with `RX_Ack` asserted on the commit edge: `RX_Data` = 55'h2 and `RX_Data_Valid` stays high. No `RX_Overrun`.
- `Rst_n` pulsed low after 20 data bits of a frame, then the full frame 55'h3 is sent: outputs read 0 during reset, then a single valid frame 55'h3 is received.
- With `RX_PARITY_EN`, frame 55'h1 sent with parity bit 0 (wrong): `RX_Parity_Err` pulses once and `RX_Data_Valid` stays 0. The same frame with parity bit 1 is accepted.
